// File: rtl/ibex_mem_arbiter.sv
// Shares one host memory port between the instruction-fetch and LSU ports.
// An in-order routing FIFO returns each response to the port that issued the request.
module ibex_mem_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          FixedDataPrio  = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        host_req_o,
  input  logic        host_gnt_i,
  input  logic        host_rvalid_i,
  output logic        host_we_o,
  output logic [3:0]  host_be_o,
  output logic [31:0] host_addr_o,
  output logic [31:0] host_wdata_o,
  input  logic [31:0] host_rdata_i,
  input  logic        host_err_i,

  output logic        resp_unexpected_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } src_e;

  typedef enum logic [1:0] {
    LOCK_NONE  = 2'd0,
    LOCK_INSTR = 2'd1,
    LOCK_DATA  = 2'd2
  } lock_e;

  lock_e                   lock_q, lock_d;
  src_e                    last_q;
  src_e                    sel;
  logic [CntW-1:0]         count_q;
  logic [PtrW-1:0]         wptr_q, rptr_q;
  logic [MaxOutstanding-1:0] fifo_q;

  logic full, empty, push, pop, head_data;

  assign full      = (count_q == CntMax);
  assign empty     = (count_q == '0);
  assign head_data = fifo_q[rptr_q];

  // Lock state register: holds the source whose request is waiting for grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= LOCK_NONE;
    end else begin
      lock_q <= lock_d;
    end
  end

  // Source selection and lock next-state
  always_comb begin
    sel    = SRC_INSTR;
    lock_d = lock_q;
    unique case (lock_q)
      LOCK_INSTR: sel = SRC_INSTR;
      LOCK_DATA:  sel = SRC_DATA;
      default: begin
        if (instr_req_i && data_req_i) begin
          if (FixedDataPrio) begin
            sel = SRC_DATA;
          end else begin
            sel = (last_q == SRC_DATA) ? SRC_INSTR : SRC_DATA;
          end
        end else if (data_req_i) begin
          sel = SRC_DATA;
        end
      end
    endcase
    if (host_gnt_i) begin
      lock_d = LOCK_NONE;
    end else if (host_req_o) begin
      lock_d = (sel == SRC_DATA) ? LOCK_DATA : LOCK_INSTR;
    end
  end

  assign host_req_o   = (instr_req_i | data_req_i) & ~full;
  assign host_addr_o  = !host_req_o ? 32'h0 : (sel == SRC_DATA) ? data_addr_i : instr_addr_i;
  assign host_we_o    = host_req_o & (sel == SRC_DATA) & data_we_i;
  assign host_be_o    = !host_req_o ? 4'h0 : (sel == SRC_DATA) ? data_be_i : 4'hF;
  assign host_wdata_o = (host_req_o && sel == SRC_DATA) ? data_wdata_i : 32'h0;

  assign push        = host_req_o & host_gnt_i;
  assign pop         = host_rvalid_i & ~empty;
  assign instr_gnt_o = push & (sel == SRC_INSTR);
  assign data_gnt_o  = push & (sel == SRC_DATA);

  assign instr_rvalid_o    = pop & ~head_data;
  assign data_rvalid_o     = pop & head_data;
  assign instr_err_o       = instr_rvalid_o & host_err_i;
  assign data_err_o        = data_rvalid_o & host_err_i;
  assign instr_rdata_o     = host_rdata_i;
  assign data_rdata_o      = host_rdata_i;
  assign resp_unexpected_o = host_rvalid_i & empty;

  // Routing FIFO, outstanding count and round-robin history
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      fifo_q  <= '0;
      last_q  <= SRC_DATA;
    end else begin
      count_q <= count_q + CntW'(push) - CntW'(pop);
      if (push) begin
        fifo_q[wptr_q] <= (sel == SRC_DATA);
        wptr_q         <= (wptr_q == PtrLast) ? '0 : wptr_q + PtrW'(1);
        last_q         <= sel;
      end
      if (pop) begin
        rptr_q <= (rptr_q == PtrLast) ? '0 : rptr_q + PtrW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Directed bench for ibex_mem_arbiter: round-robin/depth-2 instance plus a fixed-priority/depth-8 instance.
module tb_ibex_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        instr_req, data_req, data_we, host_gnt, host_rvalid, host_err;
  logic [31:0] instr_addr, data_addr, data_wdata, host_rdata;
  logic [3:0]  data_be;

  logic        instr_gnt, instr_rvalid, instr_err, data_gnt, data_rvalid, data_err;
  logic        host_req, host_we, resp_unexp;
  logic [31:0] instr_rdata, data_rdata, host_addr, host_wdata;
  logic [3:0]  host_be;

  logic        fp_instr_gnt, fp_instr_rvalid, fp_instr_err, fp_data_gnt, fp_data_rvalid, fp_data_err;
  logic        fp_host_req, fp_host_we, fp_resp_unexp;
  logic [31:0] fp_instr_rdata, fp_data_rdata, fp_host_addr, fp_host_wdata;
  logic [3:0]  fp_host_be;

  ibex_mem_arbiter #(.MaxOutstanding(2), .FixedDataPrio(1'b0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid),
    .instr_addr_i(instr_addr), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
    .data_req_i(data_req), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_rdata_o(data_rdata), .data_err_o(data_err),
    .host_req_o(host_req), .host_gnt_i(host_gnt), .host_rvalid_i(host_rvalid),
    .host_we_o(host_we), .host_be_o(host_be), .host_addr_o(host_addr),
    .host_wdata_o(host_wdata), .host_rdata_i(host_rdata), .host_err_i(host_err),
    .resp_unexpected_o(resp_unexp)
  );

  ibex_mem_arbiter #(.MaxOutstanding(8), .FixedDataPrio(1'b1)) u_fp (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_gnt_o(fp_instr_gnt), .instr_rvalid_o(fp_instr_rvalid),
    .instr_addr_i(instr_addr), .instr_rdata_o(fp_instr_rdata), .instr_err_o(fp_instr_err),
    .data_req_i(data_req), .data_gnt_o(fp_data_gnt), .data_rvalid_o(fp_data_rvalid),
    .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_rdata_o(fp_data_rdata), .data_err_o(fp_data_err),
    .host_req_o(fp_host_req), .host_gnt_i(host_gnt), .host_rvalid_i(host_rvalid),
    .host_we_o(fp_host_we), .host_be_o(fp_host_be), .host_addr_o(fp_host_addr),
    .host_wdata_o(fp_host_wdata), .host_rdata_i(host_rdata), .host_err_i(host_err),
    .resp_unexpected_o(fp_resp_unexp)
  );

  int checks = 0;
  int errors = 0;
  logic sb[$];        // expected response routing for u_dut: 0 = instr, 1 = data
  logic last_is_data; // reference round-robin history

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_req = 0; data_req = 0; data_we = 0; data_be = 4'h0;
    instr_addr = 0; data_addr = 0; data_wdata = 0;
    host_gnt = 0; host_rvalid = 0; host_rdata = 0; host_err = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    sb.delete();
    last_is_data = 1'b1;
    tick();
    tick();
    rst_n = 1;
    #1;
  endtask

  // Pops the scoreboard and checks routing of the response driven this cycle
  task automatic resp_check(input string tag);
    logic e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s observed=sb_empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_irv"}, 32'(instr_rvalid), 32'(!e));
      chk({tag, "_drv"}, 32'(data_rvalid), 32'(e));
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_ignt"}, 32'(instr_gnt), 0);
    chk({tag, "_dgnt"}, 32'(data_gnt), 0);
    chk({tag, "_irv"}, 32'(instr_rvalid), 0);
    chk({tag, "_drv"}, 32'(data_rvalid), 0);
    chk({tag, "_ierr"}, 32'(instr_err), 0);
    chk({tag, "_derr"}, 32'(data_err), 0);
    chk({tag, "_hreq"}, 32'(host_req), 0);
    chk({tag, "_hwe"}, 32'(host_we), 0);
    chk({tag, "_hbe"}, 32'(host_be), 0);
    chk({tag, "_haddr"}, host_addr, 0);
    chk({tag, "_hwdata"}, host_wdata, 0);
    chk({tag, "_unexp"}, 32'(resp_unexp), 0);
    chk({tag, "_fp_hreq"}, 32'(fp_host_req), 0);
  endtask

  initial begin
    do_reset();
    all_zero("rst");

    // 1: single fetch, response one cycle later
    instr_req = 1; instr_addr = 32'h80; host_gnt = 1; data_wdata = 32'h5555_5555;
    #1;
    chk("t1_ignt", 32'(instr_gnt), 1);
    chk("t1_dgnt", 32'(data_gnt), 0);
    chk("t1_haddr", host_addr, 32'h80);
    chk("t1_hbe", 32'(host_be), 32'hF);
    chk("t1_hwdata", host_wdata, 0);
    chk("t1_hwe", 32'(host_we), 0);
    sb.push_back(1'b0);
    tick();
    instr_req = 0; host_gnt = 0; host_rvalid = 1; host_rdata = 32'h13;
    #1;
    resp_check("t1_resp");
    chk("t1_irdata", instr_rdata, 32'h13);
    chk("t1_unexp", 32'(resp_unexp), 0);
    tick();

    // 2: both ports requesting, one-cycle responses
    do_reset();
    instr_req = 1; data_req = 1; instr_addr = 32'h1000; data_addr = 32'h2000; host_gnt = 1;
    for (int k = 0; k < 4; k++) begin
      logic exp_data;
      host_rvalid = (k != 0);
      #1;
      exp_data = !last_is_data;
      if (k != 0) begin
        resp_check($sformatf("t2_resp%0d", k));
        chk($sformatf("t2_fp_drv%0d", k), 32'(fp_data_rvalid), 1);
      end
      chk($sformatf("t2_ignt%0d", k), 32'(instr_gnt), 32'(!exp_data));
      chk($sformatf("t2_dgnt%0d", k), 32'(data_gnt), 32'(exp_data));
      chk($sformatf("t2_haddr%0d", k), host_addr, exp_data ? 32'h2000 : 32'h1000);
      chk($sformatf("t2_fp_dgnt%0d", k), 32'(fp_data_gnt), 1);
      chk($sformatf("t2_fp_ignt%0d", k), 32'(fp_instr_gnt), 0);
      sb.push_back(exp_data);
      last_is_data = exp_data;
      tick();
    end
    instr_req = 0; data_req = 0; host_gnt = 0; host_rvalid = 1;
    #1;
    resp_check("t2_drain");
    tick();

    // 3: lock holds the instr request while data (higher priority) arrives
    do_reset();
    instr_req = 1; instr_addr = 32'h100; data_addr = 32'h200;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) data_req = 1;
      #1;
      chk($sformatf("t3_haddr%0d", k), fp_host_addr, 32'h100);
      chk($sformatf("t3_dgnt%0d", k), 32'(fp_data_gnt), 0);
      chk($sformatf("t3_ignt%0d", k), 32'(fp_instr_gnt), 0);
      tick();
    end
    host_gnt = 1;
    #1;
    chk("t3_igrant", 32'(fp_instr_gnt), 1);
    chk("t3_haddr_g", fp_host_addr, 32'h100);
    tick();
    instr_req = 0;
    #1;
    chk("t3_dgrant", 32'(fp_data_gnt), 1);
    chk("t3_haddr_d", fp_host_addr, 32'h200);
    tick();

    // 4: depth-2 FIFO fills, stalls, and frees a slot only after the pop cycle
    do_reset();
    instr_req = 1; instr_addr = 32'h10; host_gnt = 1;
    #1;
    chk("t4_g0", 32'(instr_gnt), 1);
    sb.push_back(1'b0);
    tick();
    instr_addr = 32'h14;
    #1;
    chk("t4_g1", 32'(instr_gnt), 1);
    sb.push_back(1'b0);
    tick();
    #1;
    chk("t4_full_req", 32'(host_req), 0);
    chk("t4_full_gnt", 32'(instr_gnt), 0);
    tick();
    host_rvalid = 1; host_rdata = 32'hAAAA_0001;
    #1;
    resp_check("t4_pop");
    chk("t4_irdata", instr_rdata, 32'hAAAA_0001);
    chk("t4_nobypass", 32'(host_req), 0);
    tick();
    host_rvalid = 0;
    #1;
    chk("t4_req_again", 32'(host_req), 1);
    chk("t4_gnt_again", 32'(instr_gnt), 1);
    sb.push_back(1'b0);
    tick();
    instr_req = 0; host_gnt = 0; host_rvalid = 1;
    #1;
    resp_check("t4_drain0");
    tick();
    #1;
    resp_check("t4_drain1");
    tick();

    // 5: data write with error response
    do_reset();
    data_req = 1; data_we = 1; data_be = 4'b0011; data_wdata = 32'hDEAD_BEEF;
    data_addr = 32'h3000; host_gnt = 1;
    #1;
    chk("t5_dgnt", 32'(data_gnt), 1);
    chk("t5_hwe", 32'(host_we), 1);
    chk("t5_hbe", 32'(host_be), 32'h3);
    chk("t5_hwdata", host_wdata, 32'hDEAD_BEEF);
    chk("t5_haddr", host_addr, 32'h3000);
    sb.push_back(1'b1);
    tick();
    data_req = 0; data_we = 0; host_gnt = 0; host_rvalid = 1; host_err = 1;
    #1;
    resp_check("t5_resp");
    chk("t5_derr", 32'(data_err), 1);
    chk("t5_ierr", 32'(instr_err), 0);
    tick();

    // 6: unexpected response, then reset with two requests outstanding
    do_reset();
    host_rvalid = 1;
    #1;
    chk("t6_unexp", 32'(resp_unexp), 1);
    chk("t6_irv", 32'(instr_rvalid), 0);
    chk("t6_drv", 32'(data_rvalid), 0);
    tick();
    host_rvalid = 0;
    #1;
    chk("t6_unexp_end", 32'(resp_unexp), 0);
    instr_req = 1; host_gnt = 1;
    tick();
    tick();
    #1;
    chk("t6_full", 32'(host_req), 0);
    idle_inputs();
    rst_n = 0;
    #1;
    all_zero("t6_rst");
    tick();
    rst_n = 1;
    host_rvalid = 1;
    #1;
    chk("t6_post_unexp", 32'(resp_unexp), 1);
    chk("t6_post_irv", 32'(instr_rvalid), 0);
    tick();
    host_rvalid = 0; instr_req = 1;
    #1;
    chk("t6_post_req", 32'(host_req), 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
